servo_pwm_driver: RTL and testbench

//  Drives the four rover servo PWM lines from the single-channel command bus
//  (ServoNum, ActiveServoDuty) issued by the arm/sensor sequencers.

---
 rtl/servo_pwm_driver_if.sv | 28 ++
 rtl/servo_pwm_driver.sv | 84 ++++++++
 tb/tb_servo_pwm_driver.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/servo_pwm_driver_if.sv
// Command/status bundle between the arm/sensor sequencers and the servo PWM driver.
interface servo_pwm_driver_if #(
    parameter int unsigned DUTY_W = 21
);
    logic              EnableServoDriver;
    logic [1:0]        ServoNum;
    logic [DUTY_W-1:0] ActiveServoDuty;
    logic [3:0]        ServoPWM;
    logic              ActivePeriodFinished;

    // Sequencer side: issues commands, observes PWM lines and frame tick
    modport master (
        output EnableServoDriver,
        output ServoNum,
        output ActiveServoDuty,
        input  ServoPWM,
        input  ActivePeriodFinished
    );

    // Driver side
    modport slave (
        input  EnableServoDriver,
        input  ServoNum,
        input  ActiveServoDuty,
        output ServoPWM,
        output ActivePeriodFinished
    );
endinterface

// File: rtl/servo_pwm_driver.sv
// Four-channel servo PWM generator; per-channel duty latched only at frame boundaries.
module servo_pwm_driver #(
    parameter int unsigned PERIOD   = 2_000_000,
    parameter int unsigned MIN_DUTY = 50_000,
    parameter int unsigned MAX_DUTY = 250_000,
    parameter int unsigned DUTY_W   = 21
) (
    input  logic               clk,
    input  logic               ResetServoDriver_n,
    servo_pwm_driver_if.slave  bus
);

    localparam int unsigned NUM_CH = 4;

    localparam logic [DUTY_W-1:0] CNT_LAST = DUTY_W'(PERIOD - 1);
    localparam logic [DUTY_W-1:0] CNT_PRE  = DUTY_W'(PERIOD - 2);
    localparam logic [DUTY_W-1:0] DUTY_LO  = DUTY_W'(MIN_DUTY);
    localparam logic [DUTY_W-1:0] DUTY_HI  = DUTY_W'(MAX_DUTY);

    logic [DUTY_W-1:0] cnt;
    logic [DUTY_W-1:0] cnt_next_c;
    logic [DUTY_W-1:0] duty [NUM_CH];
    logic [DUTY_W-1:0] duty_clamped_c;
    logic [NUM_CH-1:0] armed;
    logic [NUM_CH-1:0] pwm;
    logic [NUM_CH-1:0] pwm_next_c;
    logic              apf;
    logic              apf_next_c;
    logic              frame_end_c;

    // Saturate the commanded pulse width into the mechanically safe range
    always_comb begin
        duty_clamped_c = bus.ActiveServoDuty;
        if (bus.ActiveServoDuty < DUTY_LO) begin
            duty_clamped_c = DUTY_LO;
        end else if (bus.ActiveServoDuty > DUTY_HI) begin
            duty_clamped_c = DUTY_HI;
        end
    end

    // Next frame position, frame tick and per-channel PWM levels
    always_comb begin
        frame_end_c = bus.EnableServoDriver && (cnt == CNT_LAST);
        apf_next_c  = bus.EnableServoDriver && (cnt == CNT_PRE);
        cnt_next_c  = cnt + DUTY_W'(1);
        if (!bus.EnableServoDriver || frame_end_c) begin
            cnt_next_c = '0;
        end
        pwm_next_c = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            pwm_next_c[i] = bus.EnableServoDriver && armed[i] && (cnt < duty[i]);
        end
    end

    // Frame counter and registered outputs
    always_ff @(posedge clk or negedge ResetServoDriver_n) begin
        if (!ResetServoDriver_n) begin
            cnt <= '0;
            pwm <= '0;
            apf <= 1'b0;
        end else begin
            cnt <= cnt_next_c;
            pwm <= pwm_next_c;
            apf <= apf_next_c;
        end
    end

    // Latch the addressed channel's command on the edge closing each frame
    always_ff @(posedge clk or negedge ResetServoDriver_n) begin
        if (!ResetServoDriver_n) begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                duty[i] <= '0;
            end
            armed <= '0;
        end else if (frame_end_c) begin
            duty[bus.ServoNum]  <= duty_clamped_c;
            armed[bus.ServoNum] <= 1'b1;
        end
    end

    assign bus.ServoPWM             = pwm;
    assign bus.ActivePeriodFinished = apf;

endmodule

// File: tb/tb_servo_pwm_driver.sv
// Directed + randomized frame-level check of servo_pwm_driver against a pulse-width model.
`timescale 1ns/1ps
module tb_servo_pwm_driver;

    localparam int P      = 1000;
    localparam int DMIN   = 50;
    localparam int DMAX   = 250;
    localparam int DUTY_W = 21;

    logic clk;
    logic rst_n;

    servo_pwm_driver_if #(.DUTY_W(DUTY_W)) bus ();

    servo_pwm_driver #(
        .PERIOD   (P),
        .MIN_DUTY (DMIN),
        .MAX_DUTY (DMAX),
        .DUTY_W   (DUTY_W)
    ) dut (
        .clk                (clk),
        .ResetServoDriver_n (rst_n),
        .bus                (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int frame_no = 0;

    // Model: what each servo will show in the coming frame
    int m_duty  [4];
    bit m_armed [4];

    function automatic int clamp(input int v);
        if (v < DMIN) return DMIN;
        if (v > DMAX) return DMAX;
        return v;
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_duty[i]  = 0;
            m_armed[i] = 1'b0;
        end
    endtask

    // Expected level of channel i at frame position pos: high for positions 1..duty
    function automatic int exp_level(input int i, input int pos);
        return (m_armed[i] && pos >= 1 && pos <= m_duty[i]) ? 1 : 0;
    endfunction

    task automatic noise_inputs();
        bus.ServoNum        = 2'($urandom_range(0, 3));
        bus.ActiveServoDuty = DUTY_W'($urandom_range(0, (1 << DUTY_W) - 1));
    endtask

    // One full frame; entry is just before the negedge of position 0.
    // Command (ch,d) is presented from cmd_pos onward; earlier positions see random noise.
    task automatic run_frame(input int ch, input int d, input int cmd_pos, input bit dis_last);
        int exp_w [4];
        int hi [4];
        int first [4];
        int last [4];
        int apf_n;
        int apf_at;
        for (int i = 0; i < 4; i++) begin
            exp_w[i] = m_armed[i] ? m_duty[i] : 0;
            hi[i]    = 0;
            first[i] = -1;
            last[i]  = -1;
        end
        apf_n  = 0;
        apf_at = -1;
        for (int p = 0; p < P; p++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                if (bus.ServoPWM[i] === 1'b1) begin
                    hi[i]++;
                    if (first[i] < 0) first[i] = p;
                    last[i] = p;
                end
            end
            if (bus.ActivePeriodFinished === 1'b1) begin
                apf_n++;
                apf_at = p;
            end
            if (p == cmd_pos) begin
                bus.ServoNum        = 2'(ch);
                bus.ActiveServoDuty = DUTY_W'(d);
            end else if (p < cmd_pos && $urandom_range(0, 49) == 0) begin
                noise_inputs();
            end
            if (p == P - 1) begin
                if (dis_last) begin
                    bus.EnableServoDriver = 1'b0;
                end else begin
                    m_duty[ch]  = clamp(d);
                    m_armed[ch] = 1'b1;
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            check($sformatf("f%0d ch%0d width", frame_no, i), hi[i], exp_w[i]);
            if (exp_w[i] > 0) begin
                check($sformatf("f%0d ch%0d rise", frame_no, i), first[i], 1);
                check($sformatf("f%0d ch%0d fall", frame_no, i), last[i], exp_w[i]);
            end
        end
        check($sformatf("f%0d apf count", frame_no), apf_n, 1);
        check($sformatf("f%0d apf pos", frame_no), apf_at, P - 1);
        frame_no++;
    endtask

    task automatic enable_fresh();
        @(posedge clk);
        #1 bus.EnableServoDriver = 1'b1;
    endtask

    // Global safety net against a stuck run
    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi_n;
        int apf_n;
        rst_n                 = 1'b0;
        bus.EnableServoDriver = 1'b0;
        bus.ServoNum          = '0;
        bus.ActiveServoDuty   = '0;
        model_reset();

        // Reset state
        repeat (3) @(negedge clk);
        check("reset pwm", int'(bus.ServoPWM), 0);
        check("reset apf", int'(bus.ActivePeriodFinished), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle disabled pwm", int'(bus.ServoPWM), 0);

        // 1: first frame silent, then ch0 at 60
        enable_fresh();
        run_frame(0, 60, 0, 1'b0);
        run_frame(0, 60, 0, 1'b0);

        // 2: mid-frame change to 240 does not disturb the running pulse
        run_frame(0, 240, 30, 1'b0);
        run_frame(0, 240, 0, 1'b0);

        // 3: clamping at both ends
        run_frame(0, 10, 500, 1'b0);
        run_frame(0, 2_000_000, 700, 1'b0);
        run_frame(1, 240, 0, 1'b0);

        // 4: ch1 holds 240 while ch2 is set to 60
        run_frame(2, 60, 0, 1'b0);
        run_frame(2, 60, 0, 1'b0);
        run_frame(2, 60, 0, 1'b0);

        // 6: disable mid-frame, outputs drop, then a fresh frame resumes prior duties
        for (int p = 0; p <= 100; p++) begin
            @(negedge clk);
            if (p == 100) begin
                for (int i = 0; i < 4; i++) begin
                    check($sformatf("pre-disable ch%0d", i), int'(bus.ServoPWM[i]), exp_level(i, p));
                end
                bus.EnableServoDriver = 1'b0;
            end
        end
        hi_n  = 0;
        apf_n = 0;
        repeat (1500) begin
            @(negedge clk);
            if (bus.ServoPWM !== 4'b0) hi_n++;
            if (bus.ActivePeriodFinished !== 1'b0) apf_n++;
            if ($urandom_range(0, 99) == 0) noise_inputs();
        end
        check("disabled pwm cycles", hi_n, 0);
        check("disabled apf cycles", apf_n, 0);
        enable_fresh();
        run_frame(0, 120, 0, 1'b0);

        // Disable on the last cycle: the command for ch3 is dropped
        run_frame(3, 150, 400, 1'b1);
        repeat (5) @(negedge clk);
        enable_fresh();
        run_frame(0, 120, 0, 1'b0);

        // 5: asynchronous reset mid-pulse
        for (int p = 0; p <= 20; p++) begin
            @(negedge clk);
            if (p == 20) begin
                check("pre-reset ch0", int'(bus.ServoPWM[0]), exp_level(0, p));
                rst_n = 1'b0;
                #1;
                check("async reset pwm", int'(bus.ServoPWM), 0);
                check("async reset apf", int'(bus.ActivePeriodFinished), 0);
                model_reset();
            end
        end
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        run_frame(3, 100, int'($urandom_range(0, P - 1)), 1'b0);
        run_frame(1, 30, int'($urandom_range(0, P - 1)), 1'b0);

        // Randomized commands across clamp ranges and command timing
        for (int k = 0; k < 8; k++) begin
            int ch;
            int d;
            int sel;
            ch  = int'($urandom_range(0, 3));
            sel = int'($urandom_range(0, 3));
            case (sel)
                0:       d = int'($urandom_range(0, DMIN - 1));
                1:       d = int'($urandom_range(DMAX + 1, (1 << DUTY_W) - 1));
                2:       d = (($urandom_range(0, 1) == 0) ? DMIN : DMAX);
                default: d = int'($urandom_range(DMIN, DMAX));
            endcase
            run_frame(ch, d, int'($urandom_range(0, P - 1)), 1'b0);
        end
        run_frame(0, 0, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
